// File: rtl/ram_sync_read_pkg.sv
// Shared constants and helpers for the ram_sync_read family of cache arrays.
package ram_sync_read_pkg;

    localparam int RSR_WIDTH_A_DFLT = 3;
    localparam int RSR_DATA_W_DFLT  = 32;
    localparam int RSR_TAG_W_DFLT   = 14;

    function automatic int rsr_depth(input int width_a);
        return 1 << width_a;
    endfunction

endpackage

// File: rtl/ram_sync_read_d0.sv
// Cache data array, way 0: thin wrapper around ram_sync_read.
module ram_sync_read_d0
    import ram_sync_read_pkg::*;
#(
    parameter int WIDTH_a = RSR_WIDTH_A_DFLT,
    parameter int WIDTH_d = RSR_DATA_W_DFLT
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [WIDTH_a-1:0] addr,
    input  logic [WIDTH_d-1:0] din,
    input  logic               we,
    output logic [WIDTH_d-1:0] dout
);

    ram_sync_read #(
        .WIDTH_a(WIDTH_a),
        .WIDTH_d(WIDTH_d)
    ) u_ram (
        .clock  (clock),
        .reset_n(reset_n),
        .addr   (addr),
        .din    (din),
        .we     (we),
        .dout   (dout)
    );

endmodule

// File: rtl/ram_sync_read_d1.sv
// Cache data array, way 1: thin wrapper around ram_sync_read.
module ram_sync_read_d1
    import ram_sync_read_pkg::*;
#(
    parameter int WIDTH_a = RSR_WIDTH_A_DFLT,
    parameter int WIDTH_d = RSR_DATA_W_DFLT
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [WIDTH_a-1:0] addr,
    input  logic [WIDTH_d-1:0] din,
    input  logic               we,
    output logic [WIDTH_d-1:0] dout
);

    ram_sync_read #(
        .WIDTH_a(WIDTH_a),
        .WIDTH_d(WIDTH_d)
    ) u_ram (
        .clock  (clock),
        .reset_n(reset_n),
        .addr   (addr),
        .din    (din),
        .we     (we),
        .dout   (dout)
    );

endmodule

// File: rtl/ram_sync_read_t0.sv
// Cache tag array, way 0: thin wrapper around ram_sync_read.
module ram_sync_read_t0
    import ram_sync_read_pkg::*;
#(
    parameter int WIDTH_a = RSR_WIDTH_A_DFLT,
    parameter int WIDTH_d = RSR_TAG_W_DFLT
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [WIDTH_a-1:0] addr,
    input  logic [WIDTH_d-1:0] din,
    input  logic               we,
    output logic [WIDTH_d-1:0] dout
);

    ram_sync_read #(
        .WIDTH_a(WIDTH_a),
        .WIDTH_d(WIDTH_d)
    ) u_ram (
        .clock  (clock),
        .reset_n(reset_n),
        .addr   (addr),
        .din    (din),
        .we     (we),
        .dout   (dout)
    );

endmodule

// File: rtl/ram_sync_read_t1.sv
// Cache tag array, way 1: thin wrapper around ram_sync_read.
module ram_sync_read_t1
    import ram_sync_read_pkg::*;
#(
    parameter int WIDTH_a = RSR_WIDTH_A_DFLT,
    parameter int WIDTH_d = RSR_TAG_W_DFLT
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [WIDTH_a-1:0] addr,
    input  logic [WIDTH_d-1:0] din,
    input  logic               we,
    output logic [WIDTH_d-1:0] dout
);

    ram_sync_read #(
        .WIDTH_a(WIDTH_a),
        .WIDTH_d(WIDTH_d)
    ) u_ram (
        .clock  (clock),
        .reset_n(reset_n),
        .addr   (addr),
        .din    (din),
        .we     (we),
        .dout   (dout)
    );

endmodule

// File: rtl/ram_sync_read.sv
// Single-port RAM: synchronous write, 1-cycle registered read, contents cleared by reset.
// Define RAM_SYNC_READ_WRITE_FIRST_EN for write-first same-address behaviour (default read-first).
module ram_sync_read
    import ram_sync_read_pkg::*;
#(
    parameter int WIDTH_a = RSR_WIDTH_A_DFLT,
    parameter int WIDTH_d = RSR_DATA_W_DFLT
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [WIDTH_a-1:0] addr,
    input  logic [WIDTH_d-1:0] din,
    input  logic               we,
    output logic [WIDTH_d-1:0] dout
);

    localparam int DEPTH = rsr_depth(WIDTH_a);

    logic [WIDTH_d-1:0] mem_q [DEPTH];
    logic [WIDTH_d-1:0] dout_q;
    logic [WIDTH_d-1:0] dout_d;

`ifdef RAM_SYNC_READ_WRITE_FIRST_EN
    always_comb begin
        dout_d = we ? din : mem_q[addr];
    end
`else
    always_comb begin
        dout_d = mem_q[addr];
    end
`endif

    // Array is cleared on reset so cache valid/dirty state starts known.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dout_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (we) begin
                mem_q[addr] <= din;
            end
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_ram_sync_read.sv
// Directed self-checking bench for ram_sync_read (32-bit, 8-bit and 14-bit tag builds).
module tb_ram_sync_read;

    logic        clock;
    logic        reset_n;

    logic [2:0]  addr32;
    logic [31:0] din32;
    logic        we32;
    logic [31:0] dout32, dout_d0, dout_d1;

    logic [2:0]  addr8;
    logic [7:0]  din8;
    logic        we8;
    logic [7:0]  dout8;

    logic [2:0]  addr14;
    logic [13:0] din14;
    logic        we14;
    logic [13:0] dout_t0, dout_t1;

    int n_cmp;
    int n_bad;

    ram_sync_read #(.WIDTH_a(3), .WIDTH_d(32)) u_dut32 (
        .clock(clock), .reset_n(reset_n), .addr(addr32), .din(din32), .we(we32), .dout(dout32)
    );

    ram_sync_read #(.WIDTH_a(3), .WIDTH_d(8)) u_dut8 (
        .clock(clock), .reset_n(reset_n), .addr(addr8), .din(din8), .we(we8), .dout(dout8)
    );

    ram_sync_read_d0 #(.WIDTH_a(3), .WIDTH_d(32)) u_d0 (
        .clock(clock), .reset_n(reset_n), .addr(addr32), .din(din32), .we(we32), .dout(dout_d0)
    );

    ram_sync_read_d1 #(.WIDTH_a(3), .WIDTH_d(32)) u_d1 (
        .clock(clock), .reset_n(reset_n), .addr(addr32), .din(din32), .we(we32), .dout(dout_d1)
    );

    ram_sync_read_t0 #(.WIDTH_a(3), .WIDTH_d(14)) u_t0 (
        .clock(clock), .reset_n(reset_n), .addr(addr14), .din(din14), .we(we14), .dout(dout_t0)
    );

    ram_sync_read_t1 #(.WIDTH_a(3), .WIDTH_d(14)) u_t1 (
        .clock(clock), .reset_n(reset_n), .addr(addr14), .din(din14), .we(we14), .dout(dout_t1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic [31:0] exp_rdw;
    logic [13:0] exp_t_rdw;

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        reset_n = 1'b0;
        addr32 = '0; din32 = '0; we32 = 1'b0;
        addr8  = '0; din8  = '0; we8  = 1'b0;
        addr14 = '0; din14 = '0; we14 = 1'b0;

        // Reset state, then every address reads zero
        #2;
        chk("rst_dout32", dout32, 32'h0);
        chk("rst_dout8", {24'h0, dout8}, 32'h0);
        chk("rst_dout14", {18'h0, dout_t0}, 32'h0);
        tick();
        tick();
        reset_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            addr32 = a[2:0];
            tick();
            chk($sformatf("clr32_a%0d", a), dout32, 32'h0);
        end

        // Single write, read back, neighbour untouched
        addr32 = 3'd5; din32 = 32'hDEADBEEF; we32 = 1'b1;
        tick();
        we32 = 1'b0; addr32 = 3'd5;
        tick();
        chk("wr_rd_a5", dout32, 32'hDEADBEEF);
        chk("wr_rd_a5_d0", dout_d0, 32'hDEADBEEF);
        chk("wr_rd_a5_d1", dout_d1, 32'hDEADBEEF);
        addr32 = 3'd4;
        tick();
        chk("rd_a4", dout32, 32'h0);

        // Same-edge read/write on one address
`ifdef RAM_SYNC_READ_WRITE_FIRST_EN
        exp_rdw   = 32'h22222222;
        exp_t_rdw = 14'h2ABC;
`else
        exp_rdw   = 32'h11111111;
        exp_t_rdw = 14'h0;
`endif
        addr32 = 3'd2; din32 = 32'h11111111; we32 = 1'b1;
        tick();
        din32 = 32'h22222222;
        tick();
        chk("rdw_same_edge", dout32, exp_rdw);
        we32 = 1'b0;
        tick();
        chk("rdw_next_edge", dout32, 32'h22222222);

        // Back-to-back writes then reads on the 8-bit instance
        for (int i = 0; i < 8; i++) begin
            addr8 = i[2:0]; din8 = 8'hA0 + i[7:0]; we8 = 1'b1;
            tick();
        end
        we8 = 1'b0;
        addr8 = 3'd0;
        tick();
        chk("b2b8_a0", {24'h0, dout8}, 32'hA0);
        for (int i = 1; i < 8; i++) begin
            addr8 = i[2:0];
            #2;
            chk($sformatf("b2b8_hold_a%0d", i), {24'h0, dout8}, 32'hA0 + i - 1);
            tick();
            chk($sformatf("b2b8_a%0d", i), {24'h0, dout8}, 32'hA0 + i);
        end

        // No write with we=0 while din changes
        addr32 = 3'd5; we32 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            din32 = 32'h01010101 * (i + 1);
            tick();
            chk($sformatf("we0_hold_c%0d", i), dout32, 32'hDEADBEEF);
        end

        // Tag write, then asynchronous reset mid-cycle
        addr14 = 3'd3; din14 = 14'h2ABC; we14 = 1'b1;
        tick();
        chk("tag_rdw", {18'h0, dout_t0}, {18'h0, exp_t_rdw});
        we14 = 1'b0;
        tick();
        chk("tag_rd_a3", {18'h0, dout_t0}, 32'h2ABC);
        chk("tag_rd_a3_t1", {18'h0, dout_t1}, 32'h2ABC);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_t0", {18'h0, dout_t0}, 32'h0);
        chk("async_rst_32", dout32, 32'h0);
        // Writes are ignored while reset is held
        we14 = 1'b1; din14 = 14'h1234; addr14 = 3'd3;
        tick();
        chk("rst_held_t0", {18'h0, dout_t0}, 32'h0);
        we14 = 1'b0;
        reset_n = 1'b1;
        tick();
        chk("post_rst_a3", {18'h0, dout_t0}, 32'h0);
        addr32 = 3'd5;
        tick();
        chk("post_rst_a5", dout32, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
